// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS pipeline control slice: MDU timer states,
// the hard-wired zero register and default multiply/divide latencies.
package mips_pipe_pkg;

  localparam logic [0:0] MDU_IDLE = 1'b0;
  localparam logic [0:0] MDU_BUSY = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 32;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// Busy timer for the multi-cycle multiply/divide unit: loads the latency on a
// start pulse and counts down, holding busy_o high for exactly that many cycles.
module mdu_timer
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int unsigned CntW = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = is_div_i ? CntW'(DIV_LAT) : CntW'(MUL_LAT);
        end
      end
      MDU_BUSY: begin
        // A start while busy is illegal upstream and deliberately ignored here.
        if (cnt_q == CntW'(1)) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == MDU_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use and MDU hazard
// stalls, taken-branch flushes, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        D_Rs,
  input  logic [4:0]        D_Rt,
  input  logic              D_UseRs,
  input  logic              D_UseRt,
  input  logic              D_MduOp,
  input  logic              E_MemRd,
  input  logic [4:0]        E_Rw,
  input  logic              E_MduStart,
  input  logic              E_IsDiv,
  input  logic              E_BrTaken,
  output logic              PC_En,
  output logic              FD_En,
  output logic              FD_Flush,
  output logic              DE_Flush,
  output logic              MDU_Busy,
  output logic [PERF_W-1:0] Stall_Cnt
);

  logic load_use;
  logic mdu_haz;
  logic stall;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  mdu_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (E_MduStart),
    .is_div_i (E_IsDiv),
    .busy_o   (MDU_Busy)
  );

  assign load_use = E_MemRd && (E_Rw != REG_ZERO) &&
                    ((D_UseRs && (D_Rs == E_Rw)) || (D_UseRt && (D_Rt == E_Rw)));
  assign mdu_haz  = D_MduOp && (MDU_Busy || E_MduStart);
  // Outputs read as free-running while reset is held, whatever the inputs.
  assign stall    = rst_n && (load_use || mdu_haz) && !E_BrTaken;

  always_comb begin
    PC_En    = 1'b1;
    FD_En    = 1'b1;
    FD_Flush = 1'b0;
    DE_Flush = 1'b0;
    if (rst_n && E_BrTaken) begin
      // Decode holds a wrong-path instruction, so the flush wins over any stall.
      FD_Flush = 1'b1;
      DE_Flush = 1'b1;
    end else if (stall) begin
      PC_En    = 1'b0;
      FD_En    = 1'b0;
      DE_Flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl, with a second instance
// using a 4-bit stall counter to exercise saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  D_Rs, D_Rt, E_Rw;
  logic        D_UseRs, D_UseRt, D_MduOp, E_MemRd, E_MduStart, E_IsDiv, E_BrTaken;
  logic        PC_En, FD_En, FD_Flush, DE_Flush, MDU_Busy;
  logic [15:0] Stall_Cnt;
  logic        s_pc_en, s_fd_en, s_fd_flush, s_de_flush, s_mdu_busy;
  logic [3:0]  s_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D_Rs       (D_Rs),
    .D_Rt       (D_Rt),
    .D_UseRs    (D_UseRs),
    .D_UseRt    (D_UseRt),
    .D_MduOp    (D_MduOp),
    .E_MemRd    (E_MemRd),
    .E_Rw       (E_Rw),
    .E_MduStart (E_MduStart),
    .E_IsDiv    (E_IsDiv),
    .E_BrTaken  (E_BrTaken),
    .PC_En      (PC_En),
    .FD_En      (FD_En),
    .FD_Flush   (FD_Flush),
    .DE_Flush   (DE_Flush),
    .MDU_Busy   (MDU_Busy),
    .Stall_Cnt  (Stall_Cnt)
  );

  pipe_hazard_ctrl #(
    .PERF_W (4)
  ) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .D_Rs       (D_Rs),
    .D_Rt       (D_Rt),
    .D_UseRs    (D_UseRs),
    .D_UseRt    (D_UseRt),
    .D_MduOp    (D_MduOp),
    .E_MemRd    (E_MemRd),
    .E_Rw       (E_Rw),
    .E_MduStart (E_MduStart),
    .E_IsDiv    (E_IsDiv),
    .E_BrTaken  (E_BrTaken),
    .PC_En      (s_pc_en),
    .FD_En      (s_fd_en),
    .FD_Flush   (s_fd_flush),
    .DE_Flush   (s_de_flush),
    .MDU_Busy   (s_mdu_busy),
    .Stall_Cnt  (s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    D_Rs = 5'd0; D_Rt = 5'd0; D_UseRs = 1'b0; D_UseRt = 1'b0; D_MduOp = 1'b0;
    E_MemRd = 1'b0; E_Rw = 5'd0; E_MduStart = 1'b0; E_IsDiv = 1'b0; E_BrTaken = 1'b0;
  endtask

  task automatic set_load_use();
    E_MemRd = 1'b1; E_Rw = 5'd8; D_Rs = 5'd8; D_UseRs = 1'b1;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [3:0] exp);
    @(negedge clk);
    check_eq(tag, {28'd0, PC_En, FD_En, FD_Flush, DE_Flush}, {28'd0, exp});
  endtask

  initial begin
    int n;
    idle_inputs();
    // Reset with a live load-use pattern on the inputs.
    rst_n = 1'b0;
    set_load_use();
    #12;
    check_ctrl("reset_ctrl", 4'b1100);
    check_eq("reset_busy", {31'd0, MDU_Busy}, 32'd0);
    check_eq("reset_cnt", {16'd0, Stall_Cnt}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load-use stall for one cycle.
    set_load_use();
    check_ctrl("lu_ctrl", 4'b0001);
    tick();
    idle_inputs();
    check_eq("lu_cnt", {16'd0, Stall_Cnt}, 32'd1);
    check_ctrl("lu_after", 4'b1100);

    // $0 destination is never a hazard.
    E_MemRd = 1'b1; E_Rw = 5'd0; D_Rs = 5'd0; D_UseRs = 1'b1;
    check_ctrl("zero_reg", 4'b1100);
    tick();
    idle_inputs();
    // Matching Rt that is not read is not a hazard.
    E_MemRd = 1'b1; E_Rw = 5'd9; D_Rt = 5'd9; D_UseRt = 1'b0;
    check_ctrl("unused_rt", 4'b1100);
    tick();
    D_UseRt = 1'b1;
    check_ctrl("used_rt", 4'b0001);
    tick();
    idle_inputs();
    check_eq("rt_cnt", {16'd0, Stall_Cnt}, 32'd2);

    // Taken branch overrides a load-use stall and is not counted.
    set_load_use();
    E_BrTaken = 1'b1;
    check_ctrl("br_ctrl", 4'b1111);
    tick();
    idle_inputs();
    check_eq("br_cnt", {16'd0, Stall_Cnt}, 32'd2);

    // Multiply with a dependent mflo held in decode.
    E_MduStart = 1'b1; E_IsDiv = 1'b0; D_MduOp = 1'b1;
    check_ctrl("mul_c0_ctrl", 4'b0001);
    check_eq("mul_c0_busy", {31'd0, MDU_Busy}, 32'd0);
    tick();
    E_MduStart = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("mul_c%0d_busy", c), {31'd0, MDU_Busy}, 32'd1);
      check_eq($sformatf("mul_c%0d_pc", c), {31'd0, PC_En}, 32'd0);
      tick();
    end
    check_ctrl("mul_c5_ctrl", 4'b1100);
    check_eq("mul_c5_busy", {31'd0, MDU_Busy}, 32'd0);
    check_eq("mul_cnt", {16'd0, Stall_Cnt}, 32'd7);
    idle_inputs();
    tick();

    // Divide interrupted by reset in its tenth cycle.
    E_MduStart = 1'b1; E_IsDiv = 1'b1;
    tick();
    idle_inputs();
    for (int c = 1; c < 10; c++) tick();
    @(negedge clk);
    check_eq("div_busy_c10", {31'd0, MDU_Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("div_rst_busy", {31'd0, MDU_Busy}, 32'd0);
    check_eq("div_rst_cnt", {16'd0, Stall_Cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fresh divide runs the full latency.
    E_MduStart = 1'b1; E_IsDiv = 1'b1;
    tick();
    idle_inputs();
    n = 0;
    while (MDU_Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check_eq("div_len", n, 32'd32);
    check_eq("div_cnt", {16'd0, Stall_Cnt}, 32'd0);

    // Saturation of the 4-bit counter over 20 stall cycles.
    set_load_use();
    for (int c = 0; c < 14; c++) tick();
    check_eq("sat_14", {28'd0, s_stall_cnt}, 32'd14);
    for (int c = 14; c < 20; c++) tick();
    check_eq("sat_20", {28'd0, s_stall_cnt}, 32'd15);
    check_eq("wide_20", {16'd0, Stall_Cnt}, 32'd20);
    tick();
    check_eq("sat_hold", {28'd0, s_stall_cnt}, 32'd15);
    idle_inputs();
    tick();
    check_eq("sat_idle", {28'd0, s_stall_cnt}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
